// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the instruction/data memory bus arbiter.
// State encodings, bus widths and the fixed byte-lane mask used for fetches.
package mem_bus_arbiter_pkg;

  localparam int REG_BUS_W       = 32;
  localparam int INST_ADDR_BUS_W = 32;
  localparam int SEL_W           = 4;

  localparam logic [SEL_W-1:0] FETCH_SEL = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

endpackage

// File: rtl/mem_bus_arbiter_bus_timeout_cnt.sv
// Counts cycles spent in a bus transaction.
// Flags expiry on the last permitted cycle (TIMEOUT-1).
module bus_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (cnt == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one memory port between instruction fetch and the MEM stage.
// Single outstanding transaction, data priority with fetch starvation guard, timeout and fetch flush.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       if_req,
  input  logic [INST_ADDR_BUS_W-1:0] if_addr,
  output logic [REG_BUS_W-1:0]       if_rdata,
  output logic                       if_ack,
  input  logic                       d_req,
  input  logic                       d_we,
  input  logic [SEL_W-1:0]           d_sel,
  input  logic [REG_BUS_W-1:0]       d_addr,
  input  logic [REG_BUS_W-1:0]       d_wdata,
  output logic [REG_BUS_W-1:0]       d_rdata,
  output logic                       d_ack,
  output logic                       m_cyc,
  output logic                       m_we,
  output logic [SEL_W-1:0]           m_sel,
  output logic [REG_BUS_W-1:0]       m_addr,
  output logic [REG_BUS_W-1:0]       m_wdata,
  input  logic [REG_BUS_W-1:0]       m_rdata,
  input  logic                       m_ack,
  output logic                       bus_err,
  output logic                       stallreq_if,
  output logic                       stallreq_mem
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic          drop;
  logic          gap;
  logic          expire;
  logic          fetch_ok;
  logic          grant_d;
  logic          grant_i;
  logic          done;

  bus_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == IDLE),
    .expire (expire)
  );

  // gap forces one idle cycle after a completion so the requester can retire its req
  assign fetch_ok = if_req & ~flush;
  assign grant_d  = (state == IDLE) & ~gap & d_req & ((starve_cnt < STARVE_LIM) | ~fetch_ok);
  assign grant_i  = (state == IDLE) & ~gap & ~grant_d & fetch_ok;
  assign done     = m_ack | expire;

  assign stallreq_if  = if_req & ~if_ack;
  assign stallreq_mem = d_req & ~d_ack;

  // NOTE: all state here is sequential, so every assignment uses <= to avoid ordering races.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      drop       <= 1'b0;
      gap        <= 1'b0;
      m_cyc      <= 1'b0;
      m_we       <= 1'b0;
      m_sel      <= '0;
      m_addr     <= '0;
      m_wdata    <= '0;
      if_ack     <= 1'b0;
      if_rdata   <= '0;
      d_ack      <= 1'b0;
      d_rdata    <= '0;
      bus_err    <= 1'b0;
    end else begin
      if_ack  <= 1'b0;
      d_ack   <= 1'b0;
      bus_err <= 1'b0;
      gap     <= 1'b0;

      if (!if_req || grant_i) begin
        starve_cnt <= '0;
      end else if (grant_d && fetch_ok && starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (grant_d) begin
            m_cyc   <= 1'b1;
            m_we    <= d_we;
            m_sel   <= d_sel;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            state   <= BUSY_D;
          end else if (grant_i) begin
            m_cyc   <= 1'b1;
            m_we    <= 1'b0;
            m_sel   <= FETCH_SEL;
            m_addr  <= if_addr;
            m_wdata <= '0;
            drop    <= 1'b0;
            state   <= BUSY_I;
          end
        end

        BUSY_I: begin
          if (done) begin
            m_cyc <= 1'b0;
            drop  <= 1'b0;
            gap   <= 1'b1;
            state <= IDLE;
            // a flush arriving on the completion edge discards this result as well
            if (!(drop || flush)) begin
              if_ack   <= 1'b1;
              if_rdata <= m_ack ? m_rdata : '0;
              bus_err  <= ~m_ack;
            end
          end else if (flush) begin
            drop <= 1'b1;
          end
        end

        BUSY_D: begin
          if (done) begin
            m_cyc   <= 1'b0;
            gap     <= 1'b1;
            state   <= IDLE;
            d_ack   <= 1'b1;
            d_rdata <= (m_ack && !m_we) ? m_rdata : '0;
            bus_err <= ~m_ack;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (STARVE_MAX=4, TIMEOUT=16).
// Stimulus is driven and outputs sampled 1ns after each rising edge.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_sel;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        m_cyc;
  logic        m_we;
  logic [3:0]  m_sel;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack;
  logic        bus_err;
  logic        stallreq_if;
  logic        stallreq_mem;

  int checks   = 0;
  int failures = 0;

  mem_bus_arbiter #(.STARVE_MAX(4), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_rdata     (if_rdata),
    .if_ack       (if_ack),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_sel        (d_sel),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_ack        (d_ack),
    .m_cyc        (m_cyc),
    .m_we         (m_we),
    .m_sel        (m_sel),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_rdata      (m_rdata),
    .m_ack        (m_ack),
    .bus_err      (bus_err),
    .stallreq_if  (stallreq_if),
    .stallreq_mem (stallreq_mem)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (!m_cyc && n < 8);
    check(tag, 32'(m_cyc), 32'd1);
  endtask

  task automatic complete(input logic [31:0] data);
    m_ack   = 1'b1;
    m_rdata = data;
    step();
    m_ack   = 1'b0;
    m_rdata = '0;
  endtask

  initial begin
    int n;
    rst = 1'b0; flush = 1'b0; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_sel = '0; d_addr = '0; d_wdata = '0;
    m_rdata = '0; m_ack = 1'b0;

    // reset state
    step(); step();
    check("rst_m_cyc", 32'(m_cyc), 32'd0);
    check("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    rst = 1'b1;
    step();

    // fetch only, memory acks in the second BUSY cycle
    if_req = 1'b1; if_addr = 32'h100;
    step();
    check("f_m_cyc", 32'(m_cyc), 32'd1);
    check("f_m_sel", 32'(m_sel), 32'hF);
    check("f_m_addr", m_addr, 32'h100);
    check("f_m_we", 32'(m_we), 32'd0);
    check("f_stall_busy", 32'(stallreq_if), 32'd1);
    step();
    check("f_no_early_ack", 32'(if_ack), 32'd0);
    complete(32'h3C010001);
    check("f_if_ack", 32'(if_ack), 32'd1);
    check("f_if_rdata", if_rdata, 32'h3C010001);
    check("f_m_cyc_drop", 32'(m_cyc), 32'd0);
    check("f_stall_ack", 32'(stallreq_if), 32'd0);
    if_req = 1'b0;
    step();
    check("f_ack_pulse", 32'(if_ack), 32'd0);
    check("f_rdata_hold", if_rdata, 32'h3C010001);

    // contention: data (write) wins, fetch follows after one idle cycle
    if_req = 1'b1; if_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b1; d_sel = 4'hF; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
    step();
    check("c_m_addr", m_addr, 32'h200);
    check("c_m_we", 32'(m_we), 32'd1);
    check("c_m_wdata", m_wdata, 32'hDEADBEEF);
    check("c_stall_mem", 32'(stallreq_mem), 32'd1);
    complete(32'h55555555);
    check("c_d_ack", 32'(d_ack), 32'd1);
    check("c_d_rdata_write", d_rdata, 32'd0);
    check("c_stall_mem_ack", 32'(stallreq_mem), 32'd0);
    check("c_if_ack_none", 32'(if_ack), 32'd0);
    d_req = 1'b0; d_we = 1'b0;
    step();
    check("c_gap", 32'(m_cyc), 32'd0);
    step();
    check("c_fetch_grant", 32'(m_cyc), 32'd1);
    check("c_fetch_addr", m_addr, 32'h104);
    check("c_fetch_sel", 32'(m_sel), 32'hF);
    check("c_starve_clr", 32'(dut.starve_cnt), 32'd0);
    complete(32'h11112222);
    check("c_if_ack", 32'(if_ack), 32'd1);
    check("c_if_rdata", if_rdata, 32'h11112222);
    if_req = 1'b0;
    step();

    // starvation: four data grants while fetch waits, then fetch wins
    if_req = 1'b1; if_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b0; d_sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      d_addr = 32'h400 + 32'(i) * 4;
      wait_grant($sformatf("s_grant%0d", i));
      check($sformatf("s_addr%0d", i), m_addr, 32'h400 + 32'(i) * 4);
      complete(32'hA000 + 32'(i));
      check($sformatf("s_dack%0d", i), 32'(d_ack), 32'd1);
      check($sformatf("s_drdata%0d", i), d_rdata, 32'hA000 + 32'(i));
    end
    d_addr = 32'h480;
    check("s_starve_full", 32'(dut.starve_cnt), 32'd4);
    wait_grant("s_fgrant");
    check("s_fetch_addr", m_addr, 32'h300);
    check("s_fetch_we", 32'(m_we), 32'd0);
    check("s_starve_reset", 32'(dut.starve_cnt), 32'd0);
    complete(32'h0F0F0F0F);
    check("s_if_ack", 32'(if_ack), 32'd1);
    check("s_if_rdata", if_rdata, 32'h0F0F0F0F);
    if_req = 1'b0; d_req = 1'b0;
    step();

    // timeout: no m_ack, m_cyc held for 16 BUSY cycles, then error completion
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    wait_grant("t_grant");
    n = 1;
    while (m_cyc && n < 40) begin
      step();
      if (m_cyc) n++;
    end
    check("t_busy_cycles", 32'(n), 32'd16);
    check("t_d_ack", 32'(d_ack), 32'd1);
    check("t_bus_err", 32'(bus_err), 32'd1);
    check("t_d_rdata", d_rdata, 32'd0);
    d_req = 1'b0;
    step();
    check("t_err_pulse", 32'(bus_err), 32'd0);

    // m_ack on the final cycle before timeout completes normally
    d_req = 1'b1; d_addr = 32'h504;
    wait_grant("tb_grant");
    repeat (15) step();
    check("tb_still_busy", 32'(m_cyc), 32'd1);
    complete(32'h0000A5A5);
    check("tb_d_ack", 32'(d_ack), 32'd1);
    check("tb_no_err", 32'(bus_err), 32'd0);
    check("tb_d_rdata", d_rdata, 32'h0000A5A5);
    d_req = 1'b0;
    step();

    // flush in IDLE blocks a fetch grant; flush in BUSY_I drops the result
    if_req = 1'b1; if_addr = 32'h600; flush = 1'b1;
    step();
    check("fl_idle_block", 32'(m_cyc), 32'd0);
    flush = 1'b0;
    wait_grant("fl_grant");
    check("fl_addr", m_addr, 32'h600);
    flush = 1'b1;
    step();
    flush = 1'b0;
    if_addr = 32'h700;
    complete(32'h12345678);
    check("fl_no_ack", 32'(if_ack), 32'd0);
    check("fl_rdata_hold", if_rdata, 32'h0F0F0F0F);
    check("fl_m_cyc_drop", 32'(m_cyc), 32'd0);
    check("fl_no_err", 32'(bus_err), 32'd0);
    wait_grant("fl_next_grant");
    check("fl_next_addr", m_addr, 32'h700);
    complete(32'h00000077);
    check("fl_next_ack", 32'(if_ack), 32'd1);
    check("fl_next_rdata", if_rdata, 32'h00000077);
    if_req = 1'b0;
    step();

    // reset in the middle of a data transaction
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h800; d_wdata = 32'h0000CAFE;
    wait_grant("r_grant");
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("r_m_cyc", 32'(m_cyc), 32'd0);
    check("r_d_ack", 32'(d_ack), 32'd0);
    check("r_state", 32'(dut.state), 32'(IDLE));
    check("r_starve", 32'(dut.starve_cnt), 32'd0);
    check("r_tmo", 32'(dut.u_tmo.cnt), 32'd0);
    check("r_d_rdata", d_rdata, 32'd0);
    d_we = 1'b0; d_addr = 32'h804;
    wait_grant("r_fresh_grant");
    check("r_fresh_addr", m_addr, 32'h804);
    complete(32'hBEEF0001);
    check("r_fresh_ack", 32'(d_ack), 32'd1);
    check("r_fresh_rdata", d_rdata, 32'hBEEF0001);
    d_req = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
